qspi_sram_controller: RTL and testbench
=======================================

Name: qspi_sram_controller

Overview:
- QSPI initiator that drives the external quad-SPI SRAM PMOD on the uio pins. It is the initiator-side counterpart of the SRAM responder model.
- Converts single-byte read/write requests from the core into SQI-mode SRAM transactions: command, 24-bit address, optional dummy cycles, one data byte.
- Sits between the core's memory port and the uio pad mux.
- SCK runs at clk/2, SPI mode 0.

Parameters:
- DUMMY_CYCLES, 2, SCK cycles between the last address nibble and the first read-data nibble (reads only); legal range 0..15.
- MIN_DESELECT, 2, minimum clk cycles ss_n stays high between transactions; legal range 1..15.
- READ_CMD, 8'h03, SQI read opcode.
- WRITE_CMD, 8'h02, SQI write opcode.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller accepts request this cycle
- req_we  input  1  1=write, 0=read
- req_addr  input  24  byte address
- req_wdata  input  8  write byte
- resp_valid  output  1  one-cycle pulse; transaction complete
- resp_rdata  output  8  read byte; valid with resp_valid on reads, holds value until the next read completes
- sck  output  1  SRAM clock
- ss_n  output  1  SRAM chip select, active low
- sio_out  output  4  SIO[3:0] drive value
- sio_oe  output  4  SIO drive enables, 1=drive
- sio_in  input  4  SIO[3:0] sampled value

Behaviour:
Clock and reset
- One clock: clk. Reset: rst, asynchronous, active-high.
- Reset values: ss_n=1, sck=0, sio_out=0, sio_oe=0, resp_valid=0, resp_rdata=0, state IDLE.
- Without SRAM_INIT_EN, req_ready=1 in the first cycle after rst falls.

States
- IDLE, SHIFT, DESELECT (plus INIT, see Optional Feature).

Handshake and nibble sequencing
- req_ready=1 only in IDLE. Request is accepted at the clk edge where req_valid & req_ready; addr, wdata and we are latched on that edge.
- Let T be the acceptance edge. At T+1: ss_n=0, sck=0, first nibble on sio_out.
- Nibble k (k=1..N) is driven during the low phase starting at T+2k-1; sck=1 during cycle T+2k.
- Shift order:
  - command (hi nibble, then lo nibble)
  - address bits 23:0, MSB nibble first
  - write: wdata hi nibble, then lo nibble
  - read: DUMMY_CYCLES SCK cycles, then 2 read nibbles
- sio_oe=4'hF while command, address or write-data nibbles are driven; 4'h0 during dummy and read phases.
- Read sampling: sio_in is sampled on the clk edge that raises sck (end of the low phase). The first read nibble is bits 7:4.
- N = 10 for writes, 10+DUMMY_CYCLES for reads.

Completion
- At T+2N+1: sck=0, ss_n=1, sio_oe=0, resp_valid=1 for one cycle, resp_rdata updated on reads. Enter DESELECT.
- DESELECT holds ss_n=1 for MIN_DESELECT cycles, counted from T+2N+1, then returns to IDLE.
- Earliest next acceptance edge: T+2N+MIN_DESELECT+1.

Invariants and boundary conditions
- sck toggles only while ss_n=0.
- sio_out and sio_oe change only in cycles where sck=0.
- req_valid dropping, or request inputs changing, after acceptance has no effect.
- req_valid held high continuously: back-to-back requests are serviced with exactly the MIN_DESELECT gap.
- Address 24'hFFFFFF: sent verbatim; no wrap logic in the controller.
- rst asserted mid-transaction: immediate return to reset values, no resp_valid pulse, and the transaction is abandoned.

Optional Feature:
SRAM_INIT_EN
- Defined: after rst falls the controller enters INIT and sends the EQIO opcode 8'h38 in single-bit SPI mode.
  - MSB first on sio_out[0], sio_oe=4'b0001, 8 SCK cycles at the same clk/2 timing.
  - Then ss_n=1 for MIN_DESELECT cycles, then IDLE.
  - req_ready=0 and resp_valid=0 throughout INIT; first req_ready=1 at cycle 16+MIN_DESELECT+1 after reset release.
  - rst during INIT restarts INIT.
- Undefined: no INIT state; IDLE directly after reset; the SRAM is expected to already be in SQI mode.

Test Plan:
- Reset then idle, feature off -> ss_n=1, sck=0, sio_oe=0, req_ready=1 in the first cycle after rst falls; outputs stable over 20 cycles.
- Write addr 24'h012345, data 8'hA5 at edge T -> nibbles 0,2,0,1,2,3,4,5,A,5; 10 sck pulses with oe=F; resp_valid at T+21; ss_n high T+21..T+22; next accept possible at T+23.
- Read addr 24'h012345 after that write (responder model attached, DUMMY_CYCLES=2) -> nibbles 0,3 then address; oe=0 from the 9th SCK; resp_valid at T+25 with resp_rdata=8'hA5.
- Two back-to-back requests with req_valid held high -> second ss_n falling edge exactly MIN_DESELECT+1 cycles after the first resp_valid; both complete correctly.
- rst pulsed at T+9 during a read -> ss_n=1, sck=0, oe=0 immediately; no resp_valid; the next write and read to 24'hFFFFFF succeed.
- With SRAM_INIT_EN -> after reset, sio_out[0] shifts 0,0,1,1,1,0,0,0 over 8 sck pulses with oe=4'b0001; req_ready stays low until cycle 19 (MIN_DESELECT=2).

Source files
------------

// File: rtl/qspi_sram_controller.sv
// SQI byte initiator (cmd, 24-bit addr, dummy, data nibble; SCK = clk/2 mode 0); req_ready only in IDLE,
// done 2N+1 cycles after accept. `define SRAM_INIT_EN to send EQIO 8'h38 in 1-bit SPI mode after reset.
module qspi_sram_controller #(
   parameter int unsigned DUMMY_CYCLES = 2,
   parameter int unsigned MIN_DESELECT = 2,
   parameter logic [7:0]  READ_CMD     = 8'h03,
   parameter logic [7:0]  WRITE_CMD    = 8'h02
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        resp_valid,
   output logic [7:0]  resp_rdata,
   output logic        sck,
   output logic        ss_n,
   output logic [3:0]  sio_out,
   output logic [3:0]  sio_oe,
   input  logic [3:0]  sio_in
);

   localparam logic [5:0] LAST_WR    = 6'd19;
   localparam logic [5:0] LAST_RD    = 6'(2 * (10 + DUMMY_CYCLES) - 1);
   localparam logic [4:0] RD_FIRST   = 5'(8 + DUMMY_CYCLES);
   localparam logic [3:0] DESEL_LOAD = 4'(MIN_DESELECT - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DESELECT, INIT} state_t;

`ifdef SRAM_INIT_EN
   localparam logic [7:0] EQIO_CMD  = 8'h38;
   localparam logic [5:0] LAST_INIT = 6'd15;
   localparam state_t     RST_STATE = INIT;
`else
   localparam state_t     RST_STATE = IDLE;
`endif

   state_t      r_state, w_next_state;
   logic [5:0]  r_step;
   logic [39:0] r_shift;
   logic        r_we;
   logic [7:0]  r_rx;
   logic [3:0]  r_dcnt;
   logic        r_sck, r_ss_n, r_resp_valid;
   logic [3:0]  r_sio_out, r_sio_oe;
   logic [7:0]  r_resp_rdata;

   logic [5:0]  w_last_step;
   logic        w_last_edge;
   logic        w_init_start;
   logic [4:0]  w_nib_cur, w_nib_next;
   logic [7:0]  w_cmd;

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign sck        = r_sck;
   assign ss_n       = r_ss_n;
   assign sio_out    = r_sio_out;
   assign sio_oe     = r_sio_oe;

   assign w_cmd      = req_we ? WRITE_CMD : READ_CMD;
   assign w_nib_cur  = r_step[5:1];
   assign w_nib_next = r_step[5:1] + 5'd1;

   always_comb begin
      w_last_step = r_we ? LAST_WR : LAST_RD;
`ifdef SRAM_INIT_EN
      if (r_state == INIT) w_last_step = LAST_INIT;
`endif
   end

   // Odd steps are the sck-high cycles; the last one closes the transaction.
   assign w_last_edge = r_step[0] && (r_step == w_last_step);

`ifdef SRAM_INIT_EN
   assign w_init_start = (r_state == INIT) && r_ss_n;
`else
   assign w_init_start = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RST_STATE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (req_valid) w_next_state = SHIFT;
         DESELECT: if (r_dcnt == 4'd0) w_next_state = IDLE;
         default:  if (w_last_edge) w_next_state = DESELECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step       <= 6'd0;
         r_shift      <= 40'd0;
         r_we         <= 1'b0;
         r_rx         <= 8'd0;
         r_dcnt       <= 4'd0;
         r_sck        <= 1'b0;
         r_ss_n       <= 1'b1;
         r_sio_out    <= 4'h0;
         r_sio_oe     <= 4'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 8'd0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  r_ss_n    <= 1'b0;
                  r_sck     <= 1'b0;
                  r_step    <= 6'd0;
                  r_sio_oe  <= 4'hF;
                  r_sio_out <= w_cmd[7:4];
                  r_shift   <= {w_cmd[3:0], req_addr, req_wdata, 4'h0};
               end
            end
            DESELECT: begin
               if (r_dcnt != 4'd0) r_dcnt <= r_dcnt - 4'd1;
            end
            default: begin
`ifdef SRAM_INIT_EN
               if (w_init_start) begin
                  r_we      <= 1'b1;
                  r_ss_n    <= 1'b0;
                  r_sck     <= 1'b0;
                  r_step    <= 6'd0;
                  r_sio_oe  <= 4'b0001;
                  r_sio_out <= {3'b000, EQIO_CMD[7]};
                  r_shift   <= {EQIO_CMD[6:0], 33'd0};
               end else
`endif
               begin
                  r_step <= r_step + 6'd1;
                  if (!r_step[0]) begin
                     r_sck <= 1'b1;
                     if (r_state == SHIFT && !r_we && w_nib_cur >= RD_FIRST)
                        r_rx <= {r_rx[3:0], sio_in};
                  end else if (w_last_edge) begin
                     r_sck     <= 1'b0;
                     r_ss_n    <= 1'b1;
                     r_sio_oe  <= 4'h0;
                     r_sio_out <= 4'h0;
                     r_dcnt    <= DESEL_LOAD;
                     if (r_state == SHIFT) begin
                        r_resp_valid <= 1'b1;
                        if (!r_we) r_resp_rdata <= r_rx;
                     end
                  end else begin
                     r_sck <= 1'b0;
                     if (r_state == INIT) begin
                        r_sio_out <= {3'b000, r_shift[39]};
                        r_shift   <= {r_shift[38:0], 1'b0};
                     end else if (r_we || w_nib_next < 5'd8) begin
                        r_sio_out <= r_shift[39:36];
                        r_shift   <= {r_shift[35:0], 4'h0};
                     end else begin
                        // Bus turnaround: release SIO for dummy and read nibbles.
                        r_sio_out <= 4'h0;
                        r_sio_oe  <= 4'h0;
                     end
                  end
               end
            end
         endcase
      end
   end

   wire w_unused_init = w_init_start;

endmodule

// File: tb/tb_qspi_sram_controller.sv
// Self-checking bench for qspi_sram_controller with a behavioural SQI SRAM responder and scoreboard.
`timescale 1ns/1ps
module tb_qspi_sram_controller;
   localparam int D = 2;
   localparam int M = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [23:0] req_addr = 24'd0;
   logic [7:0]  req_wdata = 8'd0;
   logic        req_ready, resp_valid, sck, ss_n;
   logic [7:0]  resp_rdata;
   logic [3:0]  sio_out, sio_oe;
   logic [3:0]  sio_in = 4'h0;

   always #5 clk = ~clk;

   qspi_sram_controller #(.DUMMY_CYCLES(D), .MIN_DESELECT(M), .READ_CMD(8'h03), .WRITE_CMD(8'h02)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .sck(sck), .ss_n(ss_n), .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in));

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct { logic we; logic [23:0] addr; logic [7:0] wd; logic [7:0] rd; int acc; } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   logic [7:0] last_rd_exp = 8'h00;

   // Responder model state
   logic [7:0]  mem [logic [23:0]];
   int          m_cnt = 0;
   logic        m_sck_q = 1'b0, ss_q = 1'b1;
   logic [39:0] m_hdr = 40'd0;
   logic [7:0]  m_cmd = 8'd0, m_wd = 8'd0, m_rd;
   logic [23:0] m_addr = 24'd0;
   int          n_resp = 0, last_resp_cyc = 0, prev_resp_cyc = 0, last_fall_cyc = 0;

   always @(negedge clk) begin
      if (resp_valid) begin
         n_resp++;
         prev_resp_cyc = last_resp_cyc;
         last_resp_cyc = cyc;
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp: resp_valid at cycle %0d with nothing outstanding", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("latency", 64'(cyc - mon_e.acc), mon_e.we ? 64'd20 : 64'(2 * (10 + D)));
            check("cmd", {56'd0, m_cmd}, mon_e.we ? 64'h02 : 64'h03);
            check("addr", {40'd0, m_addr}, {40'd0, mon_e.addr});
            if (mon_e.we) begin
               check("wdata", {56'd0, m_wd}, {56'd0, mon_e.wd});
               check("rdata_hold", {56'd0, resp_rdata}, {56'd0, last_rd_exp});
            end else begin
               check("rdata", {56'd0, resp_rdata}, {56'd0, mon_e.rd});
               last_rd_exp = mon_e.rd;
            end
         end
      end
      if (ss_q && !ss_n) last_fall_cyc = cyc;
      ss_q = ss_n;
      if (ss_n) begin
         m_cnt = 0;
      end else if (sck && !m_sck_q) begin
         m_hdr = {m_hdr[35:0], sio_out};
         m_cnt++;
         if (m_cnt == 2) m_cmd = m_hdr[7:0];
         if (m_cnt == 8) m_addr = m_hdr[23:0];
         if (m_cnt == 10 && m_cmd == 8'h02) begin
            m_wd = m_hdr[7:0];
            mem[m_addr] = m_wd;
         end
      end
      m_sck_q = sck;
      m_rd = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
      sio_in = 4'h0;
      if (!ss_n && m_cmd == 8'h03 && m_cnt == 8 + D) sio_in = m_rd[7:4];
      if (!ss_n && m_cmd == 8'h03 && m_cnt == 9 + D) sio_in = m_rd[3:0];
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("ready_wait", {63'd0, ok}, 64'd1);
   endtask

   task automatic push(input logic we, input logic [23:0] addr, input logic [7:0] wd, input logic [7:0] rd);
      exp_t e;
      e.we = we; e.addr = addr; e.wd = wd; e.rd = rd; e.acc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   // Drives one request and checks every cycle of the bus against the nibble schedule.
   task automatic run_txn(input logic we, input logic [23:0] addr, input logic [7:0] wd,
                          input logic [7:0] rd, input int abort_at);
      logic [39:0] bits;
      logic [3:0]  oe_e;
      logic [7:0]  act, exp;
      int          n;
      bit          ok;
      bits = {(we ? 8'h02 : 8'h03), addr, wd};
      n = we ? 10 : 10 + D;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      wait_ready(ok);
      if (!ok) begin
         req_valid = 1'b0;
         return;
      end
      push(we, addr, wd, rd);
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
      for (int m = 1; m <= 2 * n + 3; m++) begin
         if (m == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_out", {56'd0, ss_n, sck, sio_oe, resp_valid, 1'b0}, {56'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
            last_rd_exp = 8'h00;
            #1;
            check("abort_ready", {63'd0, req_ready}, 64'd1);
            return;
         end
         oe_e = (we || (m - 1) / 2 < 8) ? 4'hF : 4'h0;
         act = {ss_n, sck, sio_oe, req_ready, resp_valid};
         if (m <= 2 * n) exp = {1'b0, (m % 2 == 0), oe_e, 1'b0, 1'b0};
         else if (m == 2 * n + 1) exp = {1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
         else if (m == 2 * n + 2) exp = {1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
         else exp = {1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
         check($sformatf("bus_m%0d", m), {56'd0, act}, {56'd0, exp});
         if (m <= 2 * n && oe_e == 4'hF)
            check($sformatf("nibble_m%0d", m), {60'd0, sio_out}, {60'd0, bits[39 - 4 * ((m - 1) / 2) -: 4]});
         @(negedge clk);
      end
   endtask

   typedef struct { logic we; logic [23:0] addr; logic [7:0] wd; logic [7:0] rd; } vec_t;
   vec_t vecs[8];

   initial begin
      bit ok;
      int resp_snap;
      logic [7:0] eqio;
      vecs[0] = '{1'b1, 24'h012345, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 24'h012345, 8'h00, 8'hA5};
      vecs[2] = '{1'b1, 24'hFFFFFF, 8'h3C, 8'h00};
      vecs[3] = '{1'b1, 24'h000000, 8'hC3, 8'h00};
      vecs[4] = '{1'b0, 24'hFFFFFF, 8'h00, 8'h3C};
      vecs[5] = '{1'b0, 24'h000000, 8'h00, 8'hC3};
      vecs[6] = '{1'b1, 24'h800001, 8'h5A, 8'h00};
      vecs[7] = '{1'b0, 24'h800001, 8'h00, 8'h5A};

      repeat (3) @(negedge clk);
      check("reset_vals", {48'd0, ss_n, sck, sio_out, sio_oe, resp_valid, resp_rdata},
            {48'd0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00});
      rst = 1'b0;
`ifdef SRAM_INIT_EN
      eqio = 8'h38;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check($sformatf("init_ready_k%0d", k), {63'd0, req_ready}, {63'd0, (k >= 16 + M + 1)});
         if (k <= 16)
            check($sformatf("init_bus_k%0d", k), {57'd0, ss_n, sck, sio_oe, sio_out[0]},
                  {57'd0, 1'b0, (k % 2 == 0), 4'b0001, eqio[7 - (k - 1) / 2]});
      end
`else
      eqio = 8'h00;
      #1;
      check("ready_after_rst", {63'd0, req_ready}, 64'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle_stable", {44'd0, eqio, ss_n, sck, sio_out, sio_oe, resp_valid, req_ready, resp_rdata},
               {44'd0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'h00});
      end
`endif

      for (int i = 0; i < 8; i++) run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rd, 0);
      drain();

      // Back-to-back with req_valid held high.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h00AB12; req_wdata = 8'h7E;
      wait_ready(ok);
      push(1'b1, 24'h00AB12, 8'h7E, 8'h00);
      @(negedge clk);
      req_we = 1'b0; req_wdata = 8'h11;
      wait_ready(ok);
      push(1'b0, 24'h00AB12, 8'h11, 8'h7E);
      @(negedge clk);
      req_valid = 1'b0;
      drain();
      check("b2b_gap", 64'(last_fall_cyc - prev_resp_cyc), 64'(M + 1));

      // Reset in the middle of a read, then the top address.
      run_txn(1'b0, 24'h012345, 8'h00, 8'hA5, 9);
      resp_snap = n_resp;
      repeat (30) @(negedge clk);
      check("no_resp_after_abort", 64'(n_resp), 64'(resp_snap));
      run_txn(1'b1, 24'hFFFFFF, 8'h96, 8'h00, 0);
      run_txn(1'b0, 24'hFFFFFF, 8'h00, 8'h96, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
